display_mode_sequencer: RTL
===========================

# display_mode_sequencer

Control-plane sequencer for the pixel-clock generators. It selects one of `MODES` clock-generator instances (480p/600p/720p/1080p), resets it, and waits for a stable lock with timeout and retry. Only then does it release the display pipeline reset. It also accepts run-time mode-change requests through a req/ack handshake. It runs on the board system clock, upstream of the clock mux and the timing generator.

## Interface
- `MODES`, 4: number of clock-generator instances.
- `MODE_W`, 2: width of mode index, `$clog2(MODES)`.
- `DEFAULT_MODE`, 0: mode brought up after reset.
- `RST_HOLD`, 16: cycles a generator reset is held high.
- `LOCK_TIMEOUT`, 65536: cycles allowed for lock before a retry.
- `LOCK_STABLE`, 1024: consecutive locked cycles required before running.
- `RETRIES`, 3: lock attempts per mode before fault.

Ports:
- `i_clk`  in  1  system clock (100 MHz).
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_mode_req`  in  1  mode-change request; held until `o_mode_ack` or `o_mode_nak`.
- `i_mode`  in  MODE_W  requested mode; stable while `i_mode_req` is high.
- `o_mode_ack`  out  1  one-cycle pulse: request accepted.
- `o_mode_nak`  out  1  one-cycle pulse: request rejected because `i_mode >= MODES`.
- `i_locked`  in  MODES  per-generator lock; asynchronous, synchronized internally.
- `o_clk_rst`  out  MODES  per-generator reset, active-high.
- `o_clk_sel`  out  MODE_W  clock mux select.
- `o_disp_rst`  out  1  display pipeline reset, active-high.
- `o_ready`  out  1  selected clock locked and stable; display running.
- `o_mode`  out  MODE_W  current mode.
- `o_fault`  out  1  sticky: retries exhausted.

## Operation
- States: GEN_RST, WAIT_LOCK, STABLE, RUN, FAULT.
- Reset values:
  - state GEN_RST with target `DEFAULT_MODE`
  - `o_clk_rst` all ones
  - `o_disp_rst` = 1
  - `o_ready` = 0, `o_fault` = 0, `o_mode_ack` = 0, `o_mode_nak` = 0
  - `o_clk_sel` = `o_mode` = `DEFAULT_MODE`
  - counters = 0
- Non-target generators always have `o_clk_rst` = 1.
- GEN_RST: target reset = 1 for `RST_HOLD` cycles, then go to WAIT_LOCK. `o_clk_sel` and `o_mode` update on entry only.
- WAIT_LOCK: target reset = 0 and the timeout counter runs.
  - Synced lock = 1: go to STABLE.
  - Counter reaches `LOCK_TIMEOUT-1`: increment the retry counter. If retries < `RETRIES`, go to GEN_RST; otherwise go to FAULT.
- STABLE: count consecutive synced-lock cycles.
  - Lock drops: go to WAIT_LOCK with the timeout counter cleared. The retry count is kept.
  - `LOCK_STABLE` reached: go to RUN.
- RUN: `o_ready` = 1, `o_disp_rst` = 0.
- FAULT: `o_fault` = 1, `o_disp_rst` = 1, all `o_clk_rst` = 1.
- Requests are sampled only in RUN and FAULT and ignored elsewhere (no ack); the requester keeps holding.
- Valid request: `o_mode_ack` pulses and `o_disp_rst` rises in the same cycle. Retries and `o_fault` clear, and the FSM goes to GEN_RST for the new target.
- A request for the current mode in RUN still re-sequences.
- Invalid request: `o_mode_nak` pulses and the state is unchanged.
- Lock loss in RUN: see Configuration.
- `i_rst_n` low in any state returns to reset values on the next edge, even mid-sequence.

## Timing
- `i_locked` passes a 2-flop synchronizer, adding 2 cycles of latency.
- `o_mode_ack` / `o_mode_nak` are asserted the cycle after the request is first sampled in RUN or FAULT, for exactly one cycle.
- Best-case bring-up: the target's lock rises the cycle its reset falls. `o_ready` then rises `RST_HOLD + 2 + LOCK_STABLE` cycles (±1) after entering GEN_RST.
- `o_clk_sel` never changes while `o_disp_rst` = 0.
- `o_ready` and `o_disp_rst` are complementary except in FAULT, where both are low/high as listed above.
- Counters saturate and never wrap.

## Configuration
- `DISPLAY_SEQ_AUTORECOVER_EN` defined: synced lock = 0 in RUN drops `o_ready`, raises `o_disp_rst` the next cycle, clears retries, and goes to GEN_RST for the same mode.
- Undefined: lock loss in RUN goes directly to FAULT.

## Structure
- Package `display_seq_pkg`: state enum, `RETRY_W` and counter-width helper functions, and a mode-index constant per resolution: `MODE_480P`=0, `MODE_600P`=1, `MODE_720P`=2, `MODE_1080P`=3.
- Sub-module `display_seq_sync`: parameterized N-bit 2-flop synchronizer for `i_locked`.

## Test plan
All scenarios use `RST_HOLD`=4, `LOCK_STABLE`=8, `LOCK_TIMEOUT`=32, `RETRIES`=2.
- Bring-up: lock[0] rises with its reset fall -> `o_ready` after 4+2+8 cycles (±1); `o_clk_rst` = 4'b1110; `o_mode` = 0.
- Mode change: in RUN, req mode 2 -> ack one cycle later, `o_disp_rst` = 1 the same cycle, `o_clk_sel` = 2, `o_clk_rst` = 4'b1011 after hold, `o_ready` returns.
- Timeout/fault: lock never rises -> two full GEN_RST/WAIT_LOCK cycles, then `o_fault` = 1 and all resets = 1. A request for mode 1 clears the fault and acks.
- Glitch in STABLE: lock drops at stable count 5 -> back to WAIT_LOCK, no `o_ready`. Re-lock -> `o_ready` 8 cycles after the synced lock.
- Invalid/busy: req mode 3 during WAIT_LOCK -> no ack until RUN. With `MODES`=3, req mode 3 in RUN -> `o_mode_nak` pulse, state unchanged.
- Lock loss in RUN, run once per build: `DISPLAY_SEQ_AUTORECOVER_EN` defined -> re-sequence of the same mode. Undefined -> FAULT.

Source files
------------

// File: rtl/display_seq_pkg.sv
// display_seq_pkg
// Shared types and helpers for the display mode sequencer.
//   state_t            : sequencer FSM states (also exported on the debug port)
//   MODE_480P..1080P   : clock-generator index of each supported resolution
//   cnt_w / retry_w    : bit widths needed to hold a count of 0..N
//   max3               : largest of three integers (sizes the shared counter)
package display_seq_pkg;

    typedef enum logic [2:0] {
        ST_GEN_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    localparam int MODE_480P  = 0;
    localparam int MODE_600P  = 1;
    localparam int MODE_720P  = 2;
    localparam int MODE_1080P = 3;

    // Bits required to represent every value in 0..max_count.
    function automatic int cnt_w(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    // Bits required for a retry counter that can reach 'retries'.
    function automatic int retry_w(input int retries);
        return cnt_w(retries);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/display_seq_sync.sv
// display_seq_sync
// N-bit two-flop synchronizer for the asynchronous generator lock inputs.
//   i_clk   : system clock
//   i_rst_n : synchronous active-low reset (flops clear to 0)
//   i_async : asynchronous input bits
//   o_sync  : synchronized bits, two cycles of latency
module display_seq_sync #(
    parameter int N = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_async,
    output logic [N-1:0] o_sync
);

    logic [N-1:0] meta;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            meta   <= '0;
            o_sync <= '0;
        end else begin
            meta   <= i_async;
            o_sync <= meta;
        end
    end

endmodule

// File: rtl/display_mode_sequencer.sv
// display_mode_sequencer
// Brings up one of MODES pixel-clock generators: holds its reset, waits for a
// stable lock (with timeout and retry), then releases the display pipeline.
// Accepts run-time mode changes through a req/ack/nak handshake.
//
// Ports:
//   i_clk, i_rst_n        : system clock, synchronous active-low reset
//   i_mode_req, i_mode    : mode-change request and requested mode index
//   o_mode_ack/o_mode_nak : one-cycle accept / reject (i_mode >= MODES) pulses
//   i_locked              : per-generator lock, asynchronous
//   o_clk_rst             : per-generator reset, active-high
//   o_clk_sel, o_mode     : clock mux select and current mode
//   o_disp_rst, o_ready   : display pipeline reset / display running
//   o_fault               : retries exhausted (held until a valid request)
//   o_state               : FSM state, debug visibility
//
// Build option: define DISPLAY_SEQ_AUTORECOVER_EN to re-sequence the current
// mode on lock loss in RUN; otherwise lock loss in RUN goes to FAULT.
module display_mode_sequencer
    import display_seq_pkg::*;
#(
    parameter int MODES        = 4,
    parameter int MODE_W       = (MODES > 1) ? $clog2(MODES) : 1,
    parameter int DEFAULT_MODE = MODE_480P,
    parameter int RST_HOLD     = 16,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int LOCK_STABLE  = 1024,
    parameter int RETRIES      = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_mode_req,
    input  logic [MODE_W-1:0] i_mode,
    output logic              o_mode_ack,
    output logic              o_mode_nak,
    input  logic [MODES-1:0]  i_locked,
    output logic [MODES-1:0]  o_clk_rst,
    output logic [MODE_W-1:0] o_clk_sel,
    output logic              o_disp_rst,
    output logic              o_ready,
    output logic [MODE_W-1:0] o_mode,
    output logic              o_fault,
    output state_t            o_state
);

    localparam int CNT_W   = cnt_w(max3(RST_HOLD, LOCK_TIMEOUT, LOCK_STABLE));
    localparam int RETRY_W = retry_w(RETRIES);

    localparam logic [CNT_W-1:0]   CNT_MAX      = '1;
    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = '1;
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(RETRIES);
    localparam logic [MODE_W:0]    MODES_L      = (MODE_W + 1)'(MODES);
    localparam logic [MODE_W-1:0]  DEF_MODE     = MODE_W'(DEFAULT_MODE);

    state_t              state_q, state_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [RETRY_W-1:0]  retry_q, retry_d, retry_inc;
    logic                ack_q, ack_d, nak_q, nak_d;
    logic [MODES-1:0]    lock_sync;
    logic                lock_sel;
    logic                req_take, req_valid;

    display_seq_sync #(.N(MODES)) u_lock_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_locked),
        .o_sync  (lock_sync)
    );

    // Only the target generator's lock matters.
    always_comb begin
        lock_sel = 1'b0;
        for (int i = 0; i < MODES; i++) begin
            if (mode_q == MODE_W'(i)) lock_sel = lock_sync[i];
        end
    end

    // Counters saturate instead of wrapping.
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + 1'b1;

    // Handshake: the requester raises i_mode_req with i_mode stable and holds
    // both until it sees o_mode_ack or o_mode_nak. Requests are only sampled in
    // RUN and FAULT; the response pulses for one cycle the cycle after
    // sampling, and sampling is blocked while a response is showing so a
    // still-held request cannot be answered twice.
    assign req_take  = i_mode_req && !ack_q && !nak_q &&
                       (state_q == ST_RUN || state_q == ST_FAULT);
    assign req_valid = {1'b0, i_mode} < MODES_L;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        ack_d   = 1'b0;
        nak_d   = 1'b0;

        case (state_q)
            ST_GEN_RST: begin
                if (cnt_q >= HOLD_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_sel) begin
                    // The cycle that shows the lock is the first stable one.
                    if (LOCK_STABLE <= 1) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_STABLE;
                        cnt_d   = CNT_W'(1);
                    end
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    retry_d = retry_inc;
                    cnt_d   = '0;
                    state_d = (retry_inc < RETRY_LIMIT) ? ST_GEN_RST : ST_FAULT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_STABLE: begin
                if (!lock_sel) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q >= STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RUN: begin
                if (!lock_sel) begin
`ifdef DISPLAY_SEQ_AUTORECOVER_EN
                    state_d = ST_GEN_RST;
                    retry_d = '0;
`else
                    state_d = ST_FAULT;
`endif
                    cnt_d = '0;
                end
            end
            ST_FAULT: begin
            end
            default: begin
                state_d = ST_GEN_RST;
                cnt_d   = '0;
            end
        endcase

        // A valid request overrides whatever the state logic chose.
        if (req_take) begin
            if (req_valid) begin
                ack_d   = 1'b1;
                state_d = ST_GEN_RST;
                mode_d  = i_mode;
                cnt_d   = '0;
                retry_d = '0;
            end else begin
                nak_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_GEN_RST;
            mode_q  <= DEF_MODE;
            cnt_q   <= '0;
            retry_q <= '0;
            ack_q   <= 1'b0;
            nak_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            ack_q   <= ack_d;
            nak_q   <= nak_d;
        end
    end

    // Target reset is released only while waiting for / holding lock;
    // every other generator stays in reset.
    always_comb begin
        o_clk_rst = '1;
        for (int i = 0; i < MODES; i++) begin
            if (mode_q == MODE_W'(i) &&
                (state_q == ST_WAIT_LOCK || state_q == ST_STABLE || state_q == ST_RUN))
                o_clk_rst[i] = 1'b0;
        end
    end

    // mode_q only changes when entering GEN_RST, so the mux select never
    // moves while the display is out of reset.
    assign o_clk_sel  = mode_q;
    assign o_mode     = mode_q;
    assign o_ready    = (state_q == ST_RUN);
    assign o_disp_rst = (state_q != ST_RUN);
    assign o_fault    = (state_q == ST_FAULT);
    assign o_mode_ack = ack_q;
    assign o_mode_nak = nak_q;
    assign o_state    = state_q;

endmodule
